// File: rtl/mux_sram_ctrl.sv
// Multiplexed address/data SRAM controller: ALE/SETUP/STROBE/HOLD sequencer.
// Define MUX_SRAM_BURST_EN to enable multi-beat bursts driven by burst_len.
module mux_sram_ctrl #(
  parameter int AD_W = 8,
  parameter int ADDR_W = 16,
  parameter int NUM_BANKS = 2,
  parameter int WAIT_CYC = 0,
  localparam int BK_W =
    (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int HI_W = ADDR_W - AD_W - BK_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  output logic              ready,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [AD_W-1:0]   wdata,
  input  logic [7:0]        burst_len,
  output logic [AD_W-1:0]   rdata,
  output logic              rvalid,
  output logic              wack,
  output logic              done,
  output logic              err,
  output logic [AD_W-1:0]   ad_o,
  output logic              ad_oe,
  input  logic [AD_W-1:0]   ad_i,
  output logic [HI_W-1:0]   ah_o,
  output logic              ale,
  output logic [NUM_BANKS-1:0] ce_n,
  output logic              oe_n,
  output logic              we_n
);

  typedef enum logic [2:0] {
    IDLE, ALE, SETUP, STROBE, HOLD
  } state_t;

  state_t            state_q, state_d;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [AD_W-1:0]   wdata_q;
  logic [AD_W-1:0]   rdata_q;
  logic [3:0]        wait_q;
  logic              err_q;
  logic              bad_in;
  logic              last_wait;
  logic              last_beat;
  logic [BK_W-1:0]   bank_q;

  assign bad_in =
    32'(addr[ADDR_W-1 -: BK_W]) >= NUM_BANKS;
  assign bank_q = addr_q[ADDR_W-1 -: BK_W];
  assign last_wait = wait_q == 4'(WAIT_CYC);

`ifdef MUX_SRAM_BURST_EN
  logic [7:0]      cnt_q;
  logic [ADDR_W:0] addr_nx;
  logic            nx_bad;
  logic            wrap;

  assign addr_nx = {1'b0, addr_q} + (ADDR_W+1)'(1);
  assign nx_bad = addr_nx[ADDR_W] |
    (32'(addr_nx[ADDR_W-1 -: BK_W]) >= NUM_BANKS);
  assign wrap = addr_nx[AD_W-1:0] == '0;
  assign last_beat = cnt_q == 8'd0;
`else
  logic unused_bl;
  assign unused_bl = ^burst_len;
  assign last_beat = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (req && !bad_in) state_d = ALE;
      ALE:    state_d = SETUP;
      SETUP:  state_d = STROBE;
      STROBE: if (last_wait) state_d = HOLD;
      HOLD: begin
        state_d = IDLE;
`ifdef MUX_SRAM_BURST_EN
        // Low-byte wrap needs a fresh ALE.
        if (!last_beat && !nx_bad)
          state_d = wrap ? ALE : SETUP;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
`ifdef MUX_SRAM_BURST_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      err_q   <= 1'b0;
      wait_q  <= (state_q == STROBE) ?
                 wait_q + 4'd1 : 4'd0;
      if (state_q == IDLE && req) begin
        wr_q   <= wr;
        addr_q <= addr;
        err_q  <= bad_in;
`ifdef MUX_SRAM_BURST_EN
        cnt_q  <= burst_len;
`endif
      end
      if (state_d == SETUP && state_q != SETUP)
        wdata_q <= wdata;
      if (state_q == STROBE && last_wait && !wr_q)
        rdata_q <= ad_i;
`ifdef MUX_SRAM_BURST_EN
      if (state_q == HOLD && !last_beat) begin
        addr_q <= addr_nx[ADDR_W-1:0];
        cnt_q  <= cnt_q - 8'd1;
        err_q  <= nx_bad;
      end
`endif
    end
  end

  always_comb begin
    ready  = state_q == IDLE;
    ale    = state_q == ALE;
    ad_oe  = 1'b0;
    ad_o   = '0;
    ah_o   = '0;
    ce_n   = '1;
    oe_n   = 1'b1;
    we_n   = 1'b1;
    wack   = 1'b0;
    done   = 1'b0;
    rvalid = 1'b0;
    rdata  = rdata_q;
    err    = err_q;
    if (state_q != IDLE) begin
      ah_o = addr_q[ADDR_W-BK_W-1:AD_W];
      for (int i = 0; i < NUM_BANKS; i++)
        if (bank_q == BK_W'(i)) ce_n[i] = 1'b0;
      if (state_q == ALE) begin
        ad_oe = 1'b1;
        ad_o  = addr_q[AD_W-1:0];
      end else if (wr_q) begin
        ad_oe = 1'b1;
        ad_o  = wdata_q;
      end
    end
    unique case (state_q)
      SETUP: begin
        wack = wr_q;
        oe_n = wr_q;
      end
      STROBE: begin
        we_n = !wr_q;
        oe_n = wr_q;
      end
      HOLD: begin
        rvalid = !wr_q;
        done   = last_beat;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mux_sram_ctrl.sv
// Table-driven bench for mux_sram_ctrl; two instances (2 banks/no wait,
// 3 banks/WAIT_CYC=3) with a latch-plus-SRAM model on each shared bus.
module tb_mux_sram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req, wr;
  logic [15:0] addr;
  logic [7:0]  wdata, burst_len;
  int          sel;

  logic       req0, ready0, rvalid0, wack0, done0, err0;
  logic       ad_oe0, ale0, oe_n0, we_n0;
  logic [7:0] rdata0, ad_o0, ad_i0, lat0;
  logic [6:0] ah0;
  logic [1:0] ce0;

  logic       req1, ready1, rvalid1, wack1, done1, err1;
  logic       ad_oe1, ale1, oe_n1, we_n1;
  logic [7:0] rdata1, ad_o1, ad_i1, lat1;
  logic [5:0] ah1;
  logic [2:0] ce1;

  assign req0 = req && sel == 0;
  assign req1 = req && sel == 1;

  always_latch if (ale0) lat0 = ad_o0;
  always_latch if (ale1) lat1 = ad_o1;
  assign ad_i0 = lat0 ^ 8'h3F;
  assign ad_i1 = lat1 ^ 8'h3F;

  mux_sram_ctrl u0 (
    .clk(clk), .rst_n(rst_n), .req(req0),
    .ready(ready0), .wr(wr), .addr(addr),
    .wdata(wdata), .burst_len(burst_len),
    .rdata(rdata0), .rvalid(rvalid0),
    .wack(wack0), .done(done0), .err(err0),
    .ad_o(ad_o0), .ad_oe(ad_oe0), .ad_i(ad_i0),
    .ah_o(ah0), .ale(ale0), .ce_n(ce0),
    .oe_n(oe_n0), .we_n(we_n0)
  );

  mux_sram_ctrl #(.NUM_BANKS(3), .WAIT_CYC(3)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req1),
    .ready(ready1), .wr(wr), .addr(addr),
    .wdata(wdata), .burst_len(burst_len),
    .rdata(rdata1), .rvalid(rvalid1),
    .wack(wack1), .done(done1), .err(err1),
    .ad_o(ad_o1), .ad_oe(ad_oe1), .ad_i(ad_i1),
    .ah_o(ah1), .ale(ale1), .ce_n(ce1),
    .oe_n(oe_n1), .we_n(we_n1)
  );

  logic       o_ready, o_rv, o_wack, o_done, o_err;
  logic       o_adoe, o_ale, o_oe, o_we;
  logic [7:0] o_rd, o_ad;
  logic [6:0] o_ah;
  logic [2:0] o_ce;

  always_comb begin
    if (sel == 0) begin
      o_ready = ready0; o_rv = rvalid0;
      o_wack = wack0; o_done = done0;
      o_err = err0; o_adoe = ad_oe0;
      o_ale = ale0; o_oe = oe_n0; o_we = we_n0;
      o_rd = rdata0; o_ad = ad_o0;
      o_ah = ah0; o_ce = {1'b1, ce0};
    end else begin
      o_ready = ready1; o_rv = rvalid1;
      o_wack = wack1; o_done = done1;
      o_err = err1; o_adoe = ad_oe1;
      o_ale = ale1; o_oe = oe_n1; o_we = we_n1;
      o_rd = rdata1; o_ad = ad_o1;
      o_ah = {1'b0, ah1}; o_ce = ce1;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               nm, act, exp);
    end
  endtask

  int done_cyc, ndone, we_lo, oe_lo, bad, ale_n;
  int nrv, nwack, nerr, err_cyc, ce_low;
  logic [7:0] ale_ad[2], rd_last, st_ad;
  logic [6:0] ale_ah[2];
  logic [2:0] ale_ce[2];

  task automatic observe(input int c);
    if (o_done) begin ndone++; done_cyc = c; end
    if (!o_we) begin we_lo++; st_ad = o_ad; end
    if (!o_oe) oe_lo++;
    if (!o_oe && o_adoe) bad++;
    if (!o_we && !o_oe) bad++;
    if (o_ale && (!o_we || !o_oe)) bad++;
    if (o_ready && o_ce != 3'b111) bad++;
    if (o_ce != 3'b111) ce_low++;
    if (o_ale) begin
      if (ale_n < 2) begin
        ale_ad[ale_n] = o_ad;
        ale_ah[ale_n] = o_ah;
        ale_ce[ale_n] = o_ce;
      end
      ale_n++;
    end
    if (o_rv) begin nrv++; rd_last = o_rd; end
    if (o_wack) nwack++;
    if (o_err) begin nerr++; err_cyc = c; end
  endtask

  task automatic run(input int s, input logic w,
                     input logic [15:0] a,
                     input logic [7:0] d,
                     input logic [7:0] bl);
    sel = s; wr = w; addr = a;
    wdata = d; burst_len = bl;
    done_cyc = -1; ndone = 0; we_lo = 0;
    oe_lo = 0; bad = 0; ale_n = 0; nrv = 0;
    nwack = 0; nerr = 0; err_cyc = -1;
    ce_low = 0; rd_last = '0; st_ad = '0;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      observe(c);
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    int         s;
    logic       w;
    logic [15:0] a;
    logic [7:0] d;
    logic [2:0] ce;
    logic [7:0] lo;
    logic [6:0] hi;
    logic [7:0] rd;
    int         dc;
    int         we;
    int         oe;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{0, 1'b1, 16'h0105, 8'h5A, 3'b110,
               8'h05, 7'h01, 8'h00, 4, 1, 0};
    tbl[1] = '{0, 1'b0, 16'h8003, 8'h00, 3'b101,
               8'h03, 7'h00, 8'h3C, 4, 0, 2};
    tbl[2] = '{0, 1'b0, 16'h7FFF, 8'h00, 3'b110,
               8'hFF, 7'h7F, 8'hC0, 4, 0, 2};
    tbl[3] = '{0, 1'b1, 16'hFF80, 8'hA5, 3'b101,
               8'h80, 7'h7F, 8'h00, 4, 1, 0};
    tbl[4] = '{1, 1'b1, 16'h0010, 8'h33, 3'b110,
               8'h10, 7'h00, 8'h00, 7, 4, 0};
    tbl[5] = '{1, 1'b0, 16'h4123, 8'h00, 3'b101,
               8'h23, 7'h01, 8'h1C, 7, 0, 5};

    sel = 0; req = 0; wr = 0; addr = '0;
    wdata = '0; burst_len = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int s = 0; s < 2; s++) begin
      sel = s; #1;
      chk("rst_ready", o_ready, 1);
      chk("rst_ce", o_ce, 3'b111);
      chk("rst_strb", {o_oe, o_we, o_ale, o_adoe}, 4'b1100);
      chk("rst_out", {o_ad, o_ah, o_rd}, 0);
      chk("rst_pulse", {o_rv, o_wack, o_done, o_err}, 0);
    end

    foreach (tbl[i]) begin
      run(tbl[i].s, tbl[i].w, tbl[i].a, tbl[i].d, 8'd0);
      chk($sformatf("v%0d_ale_n", i), ale_n, 1);
      chk($sformatf("v%0d_ale_ad", i), ale_ad[0], tbl[i].lo);
      chk($sformatf("v%0d_ale_ah", i), ale_ah[0], tbl[i].hi);
      chk($sformatf("v%0d_ale_ce", i), ale_ce[0], tbl[i].ce);
      chk($sformatf("v%0d_done_cyc", i), done_cyc, tbl[i].dc);
      chk($sformatf("v%0d_ndone", i), ndone, 1);
      chk($sformatf("v%0d_we_lo", i), we_lo, tbl[i].we);
      chk($sformatf("v%0d_oe_lo", i), oe_lo, tbl[i].oe);
      chk($sformatf("v%0d_nrv", i), nrv, 32'(!tbl[i].w));
      chk($sformatf("v%0d_nwack", i), nwack, 32'(tbl[i].w));
      chk($sformatf("v%0d_bad", i), bad, 0);
      chk($sformatf("v%0d_nerr", i), nerr, 0);
      if (tbl[i].w)
        chk($sformatf("v%0d_wdat", i), st_ad, tbl[i].d);
      else
        chk($sformatf("v%0d_rdat", i), rd_last, tbl[i].rd);
    end

    run(1, 1'b1, 16'hC000, 8'h11, 8'd0);
    chk("err_n", nerr, 1);
    chk("err_cyc", err_cyc, 1);
    chk("err_ce", ce_low, 0);
    chk("err_strb", we_lo + oe_lo + ale_n, 0);
    chk("err_done", ndone, 0);

`ifdef MUX_SRAM_BURST_EN
    run(0, 1'b0, 16'h00FE, 8'h00, 8'd3);
    chk("bst_nrv", nrv, 4);
    chk("bst_ale_n", ale_n, 2);
    chk("bst_ale2_ad", ale_ad[1], 8'h00);
    chk("bst_ale2_ah", ale_ah[1], 7'h01);
    chk("bst_ndone", ndone, 1);
    chk("bst_done_cyc", done_cyc, 14);
    chk("bst_bad", bad, 0);
    run(0, 1'b0, 16'hFFFE, 8'h00, 8'd3);
    chk("ovf_nrv", nrv, 2);
    chk("ovf_nerr", nerr, 1);
    chk("ovf_ndone", ndone, 0);
`else
    run(0, 1'b0, 16'h00FE, 8'h00, 8'd3);
    chk("nobst_nrv", nrv, 1);
    chk("nobst_ale_n", ale_n, 1);
    chk("nobst_ndone", ndone, 1);
    chk("nobst_done_cyc", done_cyc, 4);
`endif

    sel = 1; wr = 1'b1; addr = 16'h0020;
    wdata = 8'h77; burst_len = 8'd0;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_we_low", o_we, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_we", o_we, 1);
    chk("mid_ce", o_ce, 3'b111);
    chk("mid_ready", o_ready, 1);
    chk("mid_done", o_done, 0);
    chk("mid_adoe", o_adoe, 0);
    rst_n = 1'b1;
    ndone = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (o_done) ndone++;
    end
    chk("mid_nodone", ndone, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_sram_ctrl.md
MUX_SRAM_CTRL -- requirements
Module: mux_sram_ctrl

Interface
REQ-001 Parameter AD_W, default 8: width of the shared address/data bus and of one data word.
REQ-002 Parameter ADDR_W, default 16: host word-address width, split as {bank, high, low}.
REQ-003 Parameter NUM_BANKS, default 2: number of SRAM banks, each with its own ce_n line.
REQ-004 Parameter WAIT_CYC, default 0: extra strobe cycles for the access (0..15).
REQ-005 Derived: BK_W = max(1, clog2(NUM_BANKS)); HI_W = ADDR_W - AD_W - BK_W.
REQ-006 One clock; reset is synchronous and active-low.
REQ-007 clk  in  1  sole clock; all logic on rising edge.
REQ-008 rst_n  in  1  synchronous active-low reset.
REQ-009 req  in  1  host access request, sampled only when ready=1.
REQ-010 ready  out  1  controller idle and able to accept req.
REQ-011 wr  in  1  1 = write, 0 = read; sampled with req.
REQ-012 addr  in  ADDR_W  word address; sampled with req.
REQ-013 wdata  in  AD_W  write data; sampled on entry to SETUP.
REQ-014 burst_len  in  8  beats minus one; sampled with req (used only with MUX_SRAM_BURST_EN).
REQ-015 rdata  out  AD_W  read data, valid while rvalid=1.
REQ-016 rvalid  out  1  one-cycle pulse per completed read beat.
REQ-017 wack  out  1  one-cycle pulse when wdata has been captured.
REQ-018 done  out  1  one-cycle pulse at the end of the final beat.
REQ-019 err  out  1  one-cycle pulse when the bank index is >= NUM_BANKS.
REQ-020 ad_o  out  AD_W  shared bus drive value.
REQ-021 ad_oe  out  1  1 = controller drives the shared bus.
REQ-022 ad_i  in  AD_W  shared bus read-back.
REQ-023 ah_o  out  HI_W  non-multiplexed high address.
REQ-024 ale  out  1  address latch enable (transparent latch, high = transparent).
REQ-025 ce_n  out  NUM_BANKS  one-hot-low bank chip enables.
REQ-026 oe_n, we_n  out  1 each  SRAM output and write strobes, active low.

Function
REQ-027 The FSM states SHALL be IDLE, ALE, SETUP, STROBE, HOLD; ready=1 only in IDLE.
REQ-028 IDLE + req: capture wr/addr/burst_len; bank index out of range -> err pulse next cycle, stay IDLE, no strobe; otherwise -> ALE.
REQ-029 ALE (1 cycle): ad_o=addr low, ad_oe=1, ale=1, ah_o=addr high, selected ce_n=0.
REQ-030 SETUP (1 cycle): ale=0; write: ad_o=wdata, ad_oe=1, wack=1; read: ad_oe=0, oe_n=0.
REQ-031 STROBE (WAIT_CYC+1 cycles): write: we_n=0; read: oe_n=0; read samples ad_i into rdata on the last STROBE cycle, rvalid=1 the next cycle.
REQ-032 HOLD (1 cycle): we_n=oe_n=1, ce_n and ad_oe unchanged; single access: done=1, -> IDLE.
REQ-033 Latency req-accept to done SHALL be WAIT_CYC+4 cycles; we_n and oe_n SHALL never be low together; ale SHALL never be high while we_n or oe_n is low.
REQ-034 ad_oe SHALL be 0 whenever oe_n=0.
REQ-035 ce_n SHALL be all ones in IDLE.

Reset
REQ-036 rst_n=0 at a clock edge SHALL force IDLE, ready=1, ale=0, ad_oe=0, ce_n all ones, oe_n=we_n=1, and ad_o, ah_o, rdata, rvalid, wack, done, err all 0, including mid-access.

Configuration
REQ-037 Macro MUX_SRAM_BURST_EN defined: after HOLD with beats remaining, address increments by 1; if the low AD_W bits wrapped to 0 -> ALE (re-latch), else -> SETUP; done only after the last beat; a bank overflow mid-burst SHALL pulse err and end the burst without done.
REQ-038 Macro not defined: burst_len ignored, every access is a single beat.

Verification
REQ-039 Write addr=0x0105, wdata=0x5A, WAIT_CYC=0 -> ale cycle ad_o=0x05, ah_o=0x01, ce_n=2'b10, we_n low 1 cycle, done at cycle 4.
REQ-040 Read addr=0x8003, SRAM returns 0x3C -> ce_n=2'b01, ad_oe=0 while oe_n low, rdata=0x3C with rvalid, done at cycle 4.
REQ-041 WAIT_CYC=3 write -> we_n low exactly 4 cycles, done at cycle 7.
REQ-042 NUM_BANKS=3, addr bank=3 -> err pulse, ce_n stays 3'b111, no strobe.
REQ-043 Burst (macro on) read from 0x00FE, burst_len=3 -> 4 rvalids, second ALE before beat at 0x0100 only, one done.
REQ-044 rst_n low during STROBE of a write -> next edge we_n=1, ce_n all ones, ready=1, no done.
